// File: rtl/load_store_unit.sv
// Load/store front end for a 64 x 32-bit single-cycle data memory.
// Handles byte/half/word accesses with lane extraction, sign/zero extension and sub-word read-modify-write.
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_error,
    output logic [31:0]           resp_rdata,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-3:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic                  req_err;

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            if (off[1]) r[31:16] = wd[15:0];
            else        r[15:0]  = wd[15:0];
        end else begin
            r = wd;
        end
        return r;
    endfunction

    assign req_err = (req_size == 2'b11) ||
                     (req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d     = WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // mem_read_data reflects the word at addr_q during this cycle
                if (write_q) begin
                    mem_wdata_d = merge_lane(mem_read_data, wdata_q, size_q, addr_q[1:0]);
                    state_d     = WRITE;
                end else begin
                    rdata_d      = extract_lane(mem_read_data, size_q, addr_q[1:0], signed_q);
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = 32'h0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            mem_wdata_q  <= 32'h0;
            rdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Strobe decoded from the state register so an async reset kills an in-flight write at once
    assign req_ready      = (state_q == IDLE);
    assign mem_write      = (state_q == WRITE);
    assign mem_address    = addr_q[ADDR_WIDTH-1:2];
    assign mem_write_data = mem_wdata_q;
    assign resp_valid     = resp_valid_q;
    assign resp_error     = resp_error_q;
    assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-word data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_fail = 0;

    load_store_unit #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_rdata(resp_rdata), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address];
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [7:0] addr, input logic [31:0] wd, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rd);
        int  lat;
        int  writes;
        bit  seen;
        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; writes = 0; seen = 1'b0;
        while (!seen && lat <= 8) begin
            if (mem_write) writes++;
            if (resp_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_error"}, {31'b0, resp_error}, {31'b0, exp_err});
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_writes"}, writes, (wr && !exp_err) ? 1 : 0);
        if (!exp_err) chk({tag, "_addr"}, {26'b0, mem_address}, {26'b0, addr[7:2]});
        @(posedge clk); #1;
        chk({tag, "_after_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_after_rdata"}, resp_rdata, 32'd0);
    endtask

    logic [7:0]  b2b_addr [3];
    logic [31:0] b2b_exp  [3];
    int          acc_cyc  [3];

    initial begin
        int n_acc;
        int n_resp;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8] = 32'h12345678;
        mem[9] = 32'hCAFEF00D;

        // reset state
        #12;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_error", {31'b0, resp_error}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_address", {26'b0, mem_address}, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // word store / load
        do_req("sw",  1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        do_req("lw",  1'b0, 2'b10, 1'b1, 8'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);

        // byte store and loads
        do_req("sb",  1'b1, 2'b00, 1'b0, 8'h11, 32'hFFFFFF5A, 3, 1'b0, 32'h0);
        chk("sb_mem", mem[4], 32'hDEAD5AEF);
        do_req("lb",  1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE);
        do_req("lbu", 1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 2, 1'b0, 32'h000000DE);
        do_req("lb0", 1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 2, 1'b0, 32'hFFFFFFEF);
        do_req("lb1", 1'b0, 2'b00, 1'b1, 8'h11, 32'h0, 2, 1'b0, 32'h0000005A);

        // halfword store and loads
        do_req("sh",  1'b1, 2'b01, 1'b0, 8'h12, 32'h12348001, 3, 1'b0, 32'h0);
        chk("sh_mem", mem[4], 32'h80015AEF);
        do_req("lh",  1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 2, 1'b0, 32'hFFFF8001);
        do_req("lhu", 1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 2, 1'b0, 32'h00008001);
        do_req("lhu0", 1'b0, 2'b01, 1'b1, 8'h10, 32'h0, 2, 1'b0, 32'h00005AEF);

        // errors
        do_req("lw_mis", 1'b0, 2'b10, 1'b0, 8'h21, 32'h0, 1, 1'b1, 32'h0);
        do_req("sh_mis", 1'b1, 2'b01, 1'b0, 8'h23, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        do_req("sz_ill", 1'b1, 2'b11, 1'b0, 8'h20, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        chk("err_mem", mem[8], 32'h12345678);

        // reset during WRITE of a byte store
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 8'h10; req_wdata = 32'h000000AA;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_write", {31'b0, mem_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_write_drop", {31'b0, mem_write}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        chk("abort_mem", mem[4], 32'h80015AEF);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("abort_ready", {31'b0, req_ready}, 32'd1);
        end

        // back-to-back loads with req_valid held
        b2b_addr[0] = 8'h10; b2b_exp[0] = 32'h80015AEF;
        b2b_addr[1] = 8'h20; b2b_exp[1] = 32'h12345678;
        b2b_addr[2] = 8'h24; b2b_exp[2] = 32'hCAFEF00D;
        n_acc = 0; n_resp = 0;
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = b2b_addr[0];
        req_valid = 1'b1;
        for (int c = 0; c < 20 && n_resp < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                chk($sformatf("b2b_rdata%0d", n_resp), resp_rdata, b2b_exp[n_resp]);
                n_resp++;
            end
            if (n_acc > 0 && (c - acc_cyc[n_acc-1] == 1 || c - acc_cyc[n_acc-1] == 2))
                chk("b2b_ready_low", {31'b0, req_ready}, 32'd0);
            if (req_ready && req_valid) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc < 3) req_addr = b2b_addr[n_acc];
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", n_acc, 3);
        chk("b2b_resps", n_resp, 3);
        if (n_acc == 3) begin
            chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 3);
            chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
